// File: rtl/hot_page_queue_pkg.sv
// Shared types for the hot-page report path: record layout and field widths.
package hot_page_queue_pkg;

  localparam int ADDR_SIZE = 21;
  localparam int CNT_SIZE  = 12;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [CNT_SIZE-1:0]  cnt;
  } hot_rec_t;

  localparam int REC_W = $bits(hot_rec_t);

endpackage

// File: rtl/hot_page_queue_if.sv
// Report-in / record-out bus of the hot page queue.
// in_valid is a strobe with no ready: a report is resolved in the cycle it is high.
// out_valid/out_ready: a record transfers on any edge where both are high; out_valid
// never drops without a transfer, and out_addr/out_cnt read 0 while out_valid is low.
interface hot_page_queue_if;
  import hot_page_queue_pkg::*;

  logic                 in_valid;
  logic [ADDR_SIZE-1:0] in_addr;
  logic [CNT_SIZE-1:0]  in_cnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_SIZE-1:0] out_addr;
  logic [CNT_SIZE-1:0]  out_cnt;

  modport master (
    output in_valid, in_addr, in_cnt, out_ready,
    input  out_valid, out_addr, out_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_cnt, out_ready,
    output out_valid, out_addr, out_cnt
  );

endinterface

// File: rtl/hot_page_queue_fifo.sv
// Register-array show-ahead synchronous FIFO; rdata is the head whenever !empty.
module hot_page_queue_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hot_page_queue.sv
// Hot-page report queue: recent-address dedup filter, FIFO, dup/drop statistics.
module hot_page_queue
  import hot_page_queue_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int FILT_N    = 8,
  parameter int STAT_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   epoch,
  hot_page_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [STAT_SIZE-1:0]   dup_cnt,
  output logic [STAT_SIZE-1:0]   drop_cnt,
  output logic                   overflow
);

  localparam int FP_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;

  logic [ADDR_SIZE-1:0] filt_addr [FILT_N];
  logic [FILT_N-1:0]    filt_valid;
  logic [FP_W-1:0]      filt_ptr;

  logic     hit;
  logic     full;
  logic     empty;
  logic     pop;
  logic     push;
  logic     full_block;
  hot_rec_t wr_rec;
  hot_rec_t head;

  // Registered filter contents only, so a same-cycle repeat is never a hit.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FILT_N; i++) begin
      if (filt_valid[i] && (filt_addr[i] == bus.in_addr)) hit = 1'b1;
    end
  end

  assign pop        = bus.out_valid && bus.out_ready;
  assign full_block = full && !pop;
  assign push       = bus.in_valid && !epoch && !hit && !full_block;
  assign wr_rec     = '{addr: bus.in_addr, cnt: bus.in_cnt};

  hot_page_queue_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = !empty;
  assign bus.out_addr  = empty ? '0 : head.addr;
  assign bus.out_cnt   = empty ? '0 : head.cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_valid <= '0;
      filt_ptr   <= '0;
      dup_cnt    <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (epoch) begin
      filt_valid <= '0;
      filt_ptr   <= '0;
      dup_cnt    <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (bus.in_valid) begin
      if (hit) begin
        if (~&dup_cnt) dup_cnt <= dup_cnt + STAT_SIZE'(1);
      end else if (full_block) begin
        if (~&drop_cnt) drop_cnt <= drop_cnt + STAT_SIZE'(1);
        overflow <= 1'b1;
      end else begin
        filt_addr[filt_ptr]  <= bus.in_addr;
        filt_valid[filt_ptr] <= 1'b1;
        filt_ptr <= (filt_ptr == FP_W'(FILT_N - 1)) ? '0 : filt_ptr + 1'b1;
      end
    end
  end

endmodule
